fetch_pc_unit: RTL and testbench



---
 rtl/beta_pkg.sv | 29 ++
 rtl/fetch_pc_unit_pc_next_sel.sv | 36 +++
 rtl/fetch_pc_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared definitions for the Beta instruction-fetch slice.
// Holds the PC-select encodings driven by decode, the fixed trap and reset
// vectors, the fetch FSM state type and the PC increment rule.
package beta_pkg;

    localparam logic [2:0] PCSEL_INC   = 3'd0;
    localparam logic [2:0] PCSEL_BR    = 3'd1;
    localparam logic [2:0] PCSEL_JMP   = 3'd2;
    localparam logic [2:0] PCSEL_ILLOP = 3'd3;
    localparam logic [2:0] PCSEL_XADR  = 3'd4;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    // PC+4 touches only bits [30:0]; the supervisor bit rides along untouched
    // and the low part wraps silently.
    function automatic logic [31:0] pc_inc(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Redirect target selection for the fetch unit.
// Ports:
//   pcsel      - decode's PC select (5..7 behave as ILLOP)
//   pc_cur     - current fetch PC (supplies the supervisor bit for branches)
//   if_pc      - PC of the instruction sitting in decode
//   br_target  - branch target from decode
//   jmp_target - JMP register value from decode
//   target     - word-aligned redirect address
module pc_next_sel
    import beta_pkg::*;
(
    input  logic [2:0]  pcsel,
    input  logic [31:0] pc_cur,
    input  logic [31:0] if_pc,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    output logic [31:0] target
);

    logic [31:0] raw;

    // A JMP may drop to user mode but can never raise the supervisor bit,
    // so bit 31 is the AND of the jumping instruction's mode and the register.
    always_comb begin
        raw = ILLOP_VEC;
        case (pcsel)
            PCSEL_INC:  raw = pc_inc(if_pc);
            PCSEL_BR:   raw = {pc_cur[31], br_target[30:0]};
            PCSEL_JMP:  raw = {if_pc[31] & jmp_target[31], jmp_target[30:0]};
            PCSEL_XADR: raw = XADR_VEC;
            default:    raw = ILLOP_VEC;
        endcase
        target = {raw[31:2], 2'b00};
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Beta fetch-side PC generator and instruction-memory requester.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   imem_req/addr/ack       - instruction memory handshake (req held until ack)
//   id_stall                - decode cannot accept the presented instruction
//   id_redirect, id_pcsel   - decode PC change request and its kind
//   id_br_target/jmp_target - redirect operands
//   irq                     - level interrupt request
//   if_valid/if_pc/if_pc4   - instruction presented to the IF/ID register
//   if_flush                - kill the IF/ID instruction this cycle
//   xp_value, xadr_taken    - interrupt return address and entry pulse
module fetch_pc_unit
    import beta_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        id_stall,
    input  logic        id_redirect,
    input  logic [2:0]  id_pcsel,
    input  logic [31:0] id_br_target,
    input  logic [31:0] id_jmp_target,
    input  logic        irq,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_flush,
    output logic [31:0] xp_value,
    output logic        xadr_taken
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drain_addr;
    logic [31:0]  skid_pc;
    logic         skid_valid;
    logic [31:0]  target;
    logic [2:0]   sel_pcsel;
    logic         active;
    logic         take_irq;
    logic         do_redirect;
    logic         got;
    logic         stalled;

    // Redirect decision: decode's request beats an interrupt, and an
    // interrupt only fires on a valid user-mode instruction that is moving.
    always_comb begin
        active      = (state != IDLE);
        take_irq    = active & irq & ~if_pc[31] & if_valid & ~id_stall & ~id_redirect;
        do_redirect = active & (id_redirect | take_irq);
        sel_pcsel   = id_redirect ? id_pcsel : PCSEL_XADR;
        got         = imem_req & imem_ack;
        stalled     = id_stall & if_valid;
    end

    assign if_flush = do_redirect;

    // While draining, the stale request must keep its original address even
    // though pc already holds the redirect target.
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    pc_next_sel u_pc_next_sel (
        .pcsel      (sel_pcsel),
        .pc_cur     (pc),
        .if_pc      (if_pc),
        .br_target  (id_br_target),
        .jmp_target (id_jmp_target),
        .target     (target)
    );

    // Fetch FSM. pc always names the next instruction to be requested, so it
    // advances on every accepted ack. The IF/ID register plus the skid entry
    // form a two-deep buffer; requests stop only when both are occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_VEC;
            drain_addr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
            imem_req   <= 1'b0;
            if_valid   <= 1'b0;
            if_pc      <= RESET_VEC;
            if_pc4     <= pc_inc(RESET_VEC);
            xp_value   <= '0;
            xadr_taken <= 1'b0;
        end else begin
            xadr_taken <= take_irq;
            if (take_irq) begin
                xp_value <= if_pc4;
            end
            if (state == IDLE) begin
                state    <= FETCH;
                imem_req <= 1'b1;
            end else if (do_redirect) begin
                pc         <= target;
                skid_valid <= 1'b0;
                if_valid   <= 1'b0;
                if (imem_req && !imem_ack) begin
                    // Memory still owes us a wrong-path word; swallow it first.
                    if (state != DRAIN) begin
                        drain_addr <= pc;
                    end
                    state <= DRAIN;
                end else begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            end else if (state == DRAIN) begin
                if (imem_ack) begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            end else if (!stalled) begin
                state    <= FETCH;
                imem_req <= 1'b1;
                if (skid_valid) begin
                    if_valid   <= 1'b1;
                    if_pc      <= skid_pc;
                    if_pc4     <= pc_inc(skid_pc);
                    skid_valid <= 1'b0;
                end else if (got) begin
                    if_valid <= 1'b1;
                    if_pc    <= pc;
                    if_pc4   <= pc_inc(pc);
                end else begin
                    if_valid <= 1'b0;
                end
                if (got) begin
                    pc <= pc_inc(pc);
                end
            end else begin
                state <= HOLD;
                if (got) begin
                    skid_valid <= 1'b1;
                    skid_pc    <= pc;
                    pc         <= pc_inc(pc);
                    imem_req   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit. The reference model treats the unit
// as a two-entry queue of fetched addresses between memory and decode, with
// requests issued while the queue has room and redirects emptying it.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        id_stall;
    logic        id_redirect;
    logic [2:0]  id_pcsel;
    logic [31:0] id_br_target;
    logic [31:0] id_jmp_target;
    logic        irq;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_flush;
    logic [31:0] xp_value;
    logic        xadr_taken;

    int check_count = 0;
    int error_count = 0;

    // Reference model state.
    logic [31:0] mq[$];
    logic [31:0] next_addr;
    logic [31:0] drain_addr;
    bit          idle;
    bit          draining;
    bit          exp_xadr;
    logic [31:0] exp_xp;

    fetch_pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .id_stall      (id_stall),
        .id_redirect   (id_redirect),
        .id_pcsel      (id_pcsel),
        .id_br_target  (id_br_target),
        .id_jmp_target (id_jmp_target),
        .irq           (irq),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4),
        .if_flush      (if_flush),
        .xp_value      (xp_value),
        .xadr_taken    (xadr_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] inc4(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    function automatic bit model_req();
        return !idle && (draining || mq.size() < 2);
    endfunction

    function automatic logic [31:0] model_target(input logic [2:0] sel, input logic [31:0] br,
                                                 input logic [31:0] jmp, input logic [31:0] head,
                                                 input logic [31:0] nxt);
        logic [31:0] t;
        case (sel)
            3'd0:    t = inc4(head);
            3'd1:    t = {nxt[31], br[30:0]};
            3'd2:    t = {head[31] & jmp[31], jmp[30:0]};
            3'd4:    t = 32'h8000_0008;
            default: t = 32'h8000_0004;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        mq.delete();
        next_addr = 32'h8000_0000;
        drain_addr = '0;
        idle = 1'b1;
        draining = 1'b0;
        exp_xadr = 1'b0;
        exp_xp = '0;
    endtask

    task automatic check_regs();
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, model_req()});
        if (model_req()) begin
            checkOutput("imem_addr", imem_addr, draining ? drain_addr : next_addr);
        end
        checkOutput("if_valid", {31'd0, if_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            checkOutput("if_pc", if_pc, mq[0]);
            checkOutput("if_pc4", if_pc4, inc4(mq[0]));
        end
        checkOutput("xadr_taken", {31'd0, xadr_taken}, {31'd0, exp_xadr});
        checkOutput("xp_value", xp_value, exp_xp);
    endtask

    // One clock cycle: drive inputs at the falling edge, check the
    // combinational flush, advance the model across the rising edge and
    // check registered outputs at the next falling edge.
    task automatic applyStimulus(input bit a, input bit s, input bit r, input logic [2:0] sel,
                                 input logic [31:0] br, input logic [31:0] jmp, input bit i);
        bit          take;
        bit          req_now;
        logic [31:0] head;
        imem_ack      = a;
        id_stall      = s;
        id_redirect   = r;
        id_pcsel      = sel;
        id_br_target  = br;
        id_jmp_target = jmp;
        irq           = i;
        head    = (mq.size() > 0) ? mq[0] : 32'h0;
        req_now = model_req();
        take    = !idle && i && (mq.size() > 0) && !head[31] && !s && !r;
        #1;
        checkOutput("if_flush", {31'd0, if_flush}, {31'd0, !idle && (r || take)});
        if (idle) begin
            idle = 1'b0;
            exp_xadr = 1'b0;
        end else begin
            exp_xadr = take;
            if (take) exp_xp = inc4(head);
            if (r || take) begin
                if (req_now && !a) begin
                    if (!draining) drain_addr = next_addr;
                    draining = 1'b1;
                end else begin
                    draining = 1'b0;
                end
                next_addr = model_target(r ? sel : 3'd4, br, jmp, head, next_addr);
                mq.delete();
            end else if (draining) begin
                if (a) draining = 1'b0;
            end else begin
                if (mq.size() > 0 && !s) void'(mq.pop_front());
                if (a && req_now) begin
                    mq.push_back(next_addr);
                    next_addr = inc4(next_addr);
                end
            end
        end
        @(negedge clk);
        check_regs();
    endtask

    // Asynchronous reset in the middle of the low clock phase; outputs must
    // clear without waiting for an edge. Returns at a falling edge.
    task automatic do_reset();
        imem_ack = 0; id_stall = 0; id_redirect = 0; id_pcsel = 0;
        id_br_target = 0; id_jmp_target = 0; irq = 0;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst_if_flush", {31'd0, if_flush}, 32'd0);
        checkOutput("rst_xadr_taken", {31'd0, xadr_taken}, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'h8000_0000);
        checkOutput("rst_if_pc4", if_pc4, 32'h8000_0004);
        checkOutput("rst_xp_value", xp_value, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Ack during the IDLE cycle is ignored, then back-to-back fetches.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("first_fetch_addr", imem_addr, 32'h8000_0000);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("third_fetch_addr", imem_addr, 32'h8000_0008);

        // Three-cycle stall with an ack landing while held.
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("hold_if_pc", if_pc, 32'h8000_0004);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("skid_if_pc", if_pc, 32'h8000_0008);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("after_skid_if_pc", if_pc, 32'h8000_000C);

        // Drop to user mode at 0x40, then JMP to 8000_0100 stays in user mode.
        applyStimulus(1, 0, 1, 3'd2, 0, 32'h0000_0040, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("user_if_pc", if_pc, 32'h0000_0040);
        applyStimulus(1, 0, 1, 3'd2, 0, 32'h8000_0100, 0);
        checkOutput("jmp_fetch_addr", imem_addr, 32'h0000_0100);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Branch while a request is outstanding; ack arrives four cycles late.
        applyStimulus(0, 0, 1, 3'd1, 32'h0000_0200, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("drain_fetch_addr", imem_addr, 32'h0000_0200);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // User-mode interrupt at 0x200, then irq in supervisor mode.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("irq_xadr_taken", {31'd0, xadr_taken}, 32'd1);
        checkOutput("irq_xp_value", xp_value, 32'h0000_0204);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("irq_fetch_addr", imem_addr, 32'h8000_0008);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("sup_irq_ignored", {31'd0, xadr_taken}, 32'd0);

        // Reset mid-fetch, then restart from the reset vector.
        do_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("restart_fetch_addr", imem_addr, 32'h8000_0000);

        // Randomised traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            bit          a;
            bit          s;
            bit          r;
            bit          i;
            logic [2:0]  sel;
            if (n % 700 == 699) do_reset();
            a   = model_req() && ($urandom_range(0, 99) < 65);
            s   = $urandom_range(0, 99) < 25;
            r   = (mq.size() > 0) && ($urandom_range(0, 99) < 8);
            i   = $urandom_range(0, 99) < 15;
            sel = 3'($urandom_range(1, 7));
            applyStimulus(a, s, r, sel, $urandom, $urandom, i);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
